sram_cfg_row_controller: RTL and testbench
==========================================

Name: sram_cfg_row_controller

Overview:
- Programming/readback sequencer that sits directly upstream of the array of SRAM configuration cells.
- Accepts row-granular write/read commands from the bitstream loader over a valid/ready handshake.
- Generates per-row write/writeN and read/readN strobe pairs plus the shared column write-data bus.
- Samples the shared column read-bit bus (tristate, driven by the selected row) and returns readback data.

Parameters:
- ROWS, 8, number of cell rows (word lines)
- COLS, 16, number of cells per row (bit lines)
- ADDR_W, 3, row address width; must satisfy 2^ADDR_W >= ROWS

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  1  0 = write row, 1 = read row
- cmd_addr  in  ADDR_W  target row
- cmd_wdata  in  COLS  row data for writes
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid; set when the address is out of range
- resp_rdata  out  COLS  readback data, valid with resp_valid on a read
- row_write  out  ROWS  per-row write strobe, active-high
- row_writeN  out  ROWS  per-row write strobe, active-low
- row_read  out  ROWS  per-row read enable, active-high
- row_readN  out  ROWS  per-row read enable, active-low
- col_bitWrite  out  COLS  shared column write data
- col_bitRead  in  COLS  shared column read bus; Z is treated as 0

Behaviour:
- Output registering and reset values:
  - All array-facing outputs are registered.
  - During and after reset: row_write=0, row_writeN=all 1s, row_read=0, row_readN=all 1s, col_bitWrite=0.
  - Also under reset: cmd_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, state=IDLE.
- Strobe invariants, every cycle:
  - row_writeN == ~row_write and row_readN == ~row_read.
  - At most one bit set across row_write|row_read.
  - row_write and row_read are never both nonzero.
- States: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_DRIVE, RD_SAMPLE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op/addr/wdata.
  - addr >= ROWS -> RESP with err=1; no strobe is ever asserted.
  - Write -> WR_SETUP. Read -> RD_DRIVE.
- Write sequence:
  - WR_SETUP: col_bitWrite = latched data; no strobes (data setup cycle).
  - WR_STROBE: row_write[addr]=1, row_writeN[addr]=0 for exactly one cycle. The cell captures at the rising edge ending this cycle.
  - WR_HOLD: strobes deasserted; col_bitWrite held (hold cycle). Next state RESP.
- Read sequence:
  - RD_DRIVE: row_read[addr]=1, row_readN[addr]=0 (bus settle cycle).
  - RD_SAMPLE: read remains asserted; resp_rdata <= col_bitRead at the edge ending this cycle, with X/Z forced to 0. Next state RESP.
- RESP: resp_valid=1 for one cycle, cmd_ready=0, all strobes off; returns to IDLE.
- Latency, counted from the handshake edge (cycle 0):
  - Write: resp_valid in cycle 4.
  - Read: resp_valid in cycle 3.
  - Error: resp_valid in cycle 1.
- Throughput: one command per 5 (write), 4 (read) or 2 (error) cycles; cmd_ready is low outside IDLE.
- resp_rdata holds its value until the next read completes. It is cleared to 0 on a write response and on an error response.
- col_bitWrite returns to 0 in RESP and holds 0 in IDLE.
- Reset mid-operation: at the next edge all strobes drop, the state returns to IDLE and the command is lost without a response. A cell write completes only if WR_STROBE was active at the edge where reset was not asserted.
- cmd_valid while busy is ignored; it is not queued.

Test Plan:
- Reset, then read row 0 -> resp_valid in cycle 3, resp_err=0, resp_rdata=0x0000 (cells reset to 0).
- Write row 2 with 0xA5C3, then read row 2:
  - row_write=8'b0000_0100 for exactly one cycle, 2 cycles after the handshake.
  - col_bitWrite=0xA5C3 in the cycles before, during and after the strobe.
  - Readback is 0xA5C3.
- Every cycle of a random command mix: assert row_writeN==~row_write, row_readN==~row_read, onehot0(row_write|row_read), and never write and read together.
- ROWS=6 with cmd_addr=7 (write) -> resp_valid with resp_err=1 one cycle after the handshake; row_write and row_read remain 0 throughout.
- Assert reset during WR_SETUP of a write of 0xFFFF to row 1:
  - Strobes stay 0, no resp_valid is produced.
  - A subsequent read of row 1 returns 0x0000.
- cmd_valid held high continuously with back-to-back write and read commands -> cmd_ready high only in IDLE cycles; the second command is accepted exactly 5 cycles after the first.

Source files
------------

// File: rtl/sram_cfg_row_controller.sv
// Row-granular programming/readback sequencer for an array of SRAM configuration cells.
//
// Accepts one write-row or read-row command at a time over a valid/ready handshake and
// turns it into a fixed strobe sequence on the array:
//   write : data setup -> one-cycle write strobe -> hold -> response  (resp in cycle 4)
//   read  : read enable (settle) -> read enable (sample) -> response  (resp in cycle 3)
//   bad address (>= ROWS): straight to response with resp_err, no strobes (resp in cycle 1)
// Cycle 0 is the cycle in which cmd_valid & cmd_ready are both high.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; ready only while idle and not in reset
//   cmd_op                0 = write row, 1 = read row
//   cmd_addr, cmd_wdata   target row and write data
//   resp_valid            one-cycle completion pulse, qualified by resp_err
//   resp_rdata            readback data; held until the next read, cleared on write/error
//   row_write/_writeN     per-row write strobe pair (registered)
//   row_read/_readN       per-row read enable pair (registered)
//   col_bitWrite          shared column write data (registered, 0 outside a write)
//   col_bitRead           shared column read bus from the selected row; X/Z read as 0
module sram_cfg_row_controller #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [COLS-1:0]   cmd_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [COLS-1:0]   resp_rdata,
  output logic [ROWS-1:0]   row_write,
  output logic [ROWS-1:0]   row_writeN,
  output logic [ROWS-1:0]   row_read,
  output logic [ROWS-1:0]   row_readN,
  output logic [COLS-1:0]   col_bitWrite,
  input  logic [COLS-1:0]   col_bitRead
);

  typedef enum logic [2:0] {
    StIdle,
    StWrSetup,
    StWrStrobe,
    StWrHold,
    StRdDrive,
    StRdSample,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COLS-1:0]   wdata_q, wdata_d;
  logic              err_d;
  logic              handshake;
  logic              addr_oob;

  logic [ROWS-1:0]   row_oh_d;
  logic [ROWS-1:0]   row_write_q, row_write_d;
  logic [ROWS-1:0]   row_read_q, row_read_d;
  logic [COLS-1:0]   col_wr_q, col_wr_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [COLS-1:0]   resp_rdata_q, resp_rdata_d;
  logic [COLS-1:0]   rd_clean;

  assign cmd_ready = (state_q == StIdle) && !reset;
  assign handshake = cmd_valid && cmd_ready;
  assign addr_oob  = (32'(cmd_addr) >= ROWS);

  // Next state and latched command.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          if (addr_oob) begin
            state_d = StResp;
            err_d   = 1'b1;
          end else if (cmd_op) begin
            state_d = StRdDrive;
          end else begin
            state_d = StWrSetup;
          end
        end
      end
      StWrSetup:  state_d = StWrStrobe;
      StWrStrobe: state_d = StWrHold;
      StWrHold:   state_d = StResp;
      StRdDrive:  state_d = StRdSample;
      StRdSample: state_d = StResp;
      StResp:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Row select decoded from the address that will be current next cycle, so the
  // registered strobes line up with the state they belong to.
  always_comb begin
    row_oh_d = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      row_oh_d[i] = (addr_d == ADDR_W'(i));
    end
  end

  // Undriven or unknown bus bits read as 0.
  always_comb begin
    rd_clean = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      rd_clean[i] = (col_bitRead[i] === 1'b1);
    end
  end

  // Registered outputs computed from the next state.
  always_comb begin
    row_write_d  = '0;
    row_read_d   = '0;
    col_wr_d     = '0;
    resp_valid_d = (state_d == StResp);
    resp_err_d   = err_d;
    resp_rdata_d = resp_rdata_q;
    if (state_d == StWrStrobe) begin
      row_write_d = row_oh_d;
    end
    if ((state_d == StRdDrive) || (state_d == StRdSample)) begin
      row_read_d = row_oh_d;
    end
    if ((state_d == StWrSetup) || (state_d == StWrStrobe) || (state_d == StWrHold)) begin
      col_wr_d = wdata_d;
    end
    if (state_q == StRdSample) begin
      resp_rdata_d = rd_clean;
    end else if (state_d == StResp) begin
      resp_rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      row_write_q  <= '0;
      row_read_q   <= '0;
      col_wr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      row_write_q  <= row_write_d;
      row_read_q   <= row_read_d;
      col_wr_q     <= col_wr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Active-low copies are the inverse of the same flops, so the pairs can never disagree.
  assign row_write    = row_write_q;
  assign row_writeN   = ~row_write_q;
  assign row_read     = row_read_q;
  assign row_readN    = ~row_read_q;
  assign col_bitWrite = col_wr_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;

endmodule

// File: tb/tb_sram_cfg_row_controller.sv
// Bench for sram_cfg_row_controller with ROWS=6 so that addresses 6 and 7 are out of range.
// A simple cell-array model sits on the strobes; a reference memory updated only by
// completed write responses predicts readback data.
module tb_sram_cfg_row_controller;

  localparam int ROWS   = 6;
  localparam int COLS   = 16;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_op = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [COLS-1:0]   cmd_wdata = '0;
  logic              resp_valid;
  logic              resp_err;
  logic [COLS-1:0]   resp_rdata;
  logic [ROWS-1:0]   row_write;
  logic [ROWS-1:0]   row_writeN;
  logic [ROWS-1:0]   row_read;
  logic [ROWS-1:0]   row_readN;
  logic [COLS-1:0]   col_bitWrite;
  logic [COLS-1:0]   col_bitRead;

  sram_cfg_row_controller #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .row_write   (row_write),
    .row_writeN  (row_writeN),
    .row_read    (row_read),
    .row_readN   (row_readN),
    .col_bitWrite(col_bitWrite),
    .col_bitRead (col_bitRead)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cell array: captures at the rising edge that ends a write-strobe cycle.
  logic [COLS-1:0] cells [ROWS] = '{default: '0};
  always @(posedge clk) begin
    for (int i = 0; i < ROWS; i++) begin
      if (row_write[i]) cells[i] <= col_bitWrite;
    end
  end
  always_comb begin
    col_bitRead = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_read[i]) col_bitRead = cells[i];
    end
  end

  typedef struct {
    bit              err;
    bit              is_wr;
    int              addr;
    logic [COLS-1:0] wdata;
    logic [COLS-1:0] rdata;
    int              due;
  } exp_t;

  exp_t            exp_arr [256];
  int              n_issued = 0;
  logic [COLS-1:0] ref_mem [ROWS] = '{default: '0};

  // Last accepted command, for per-cycle strobe expectations.
  bit              rec_live = 1'b0;
  bit              rec_rd = 1'b0;
  bit              rec_err = 1'b0;
  int              rec_addr = 0;
  logic [COLS-1:0] rec_data = '0;
  int              rec_hs = 0;

  bit chk_on = 1'b0;
  int b2b_seq = 0;
  int b2b_gap = 0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Issue side: every accepted command pushes its expected response.
  exp_t e_new;
  always @(negedge clk) begin
    if (chk_on && cmd_valid && cmd_ready && !reset) begin
      e_new.is_wr = !cmd_op;
      e_new.addr  = int'(cmd_addr);
      e_new.err   = (e_new.addr >= ROWS);
      e_new.wdata = cmd_wdata;
      e_new.rdata = (!e_new.err && cmd_op) ? ref_mem[e_new.addr] : '0;
      e_new.due   = cyc + (e_new.err ? 1 : (cmd_op ? 3 : 4));
      exp_arr[n_issued & 255] = e_new;
      n_issued = n_issued + 1;
      rec_live = 1'b1;
      rec_rd   = cmd_op;
      rec_err  = e_new.err;
      rec_addr = e_new.addr;
      rec_data = cmd_wdata;
      rec_hs   = cyc;
    end
  end

  // Monitor side.
  int              n_done = 0;
  int              last_rst = -1;
  bit              prev_rst = 1'b0;
  int              b2b_seen = 0;
  bit              live, wr_cmd, rd_cmd, busy;
  int              d, lat;
  logic [ROWS-1:0] oh, ew, er, inv_w, inv_r;
  logic [COLS-1:0] ec;
  exp_t            e_pop;

  always @(negedge clk) begin
    if (chk_on) begin
      live   = rec_live && (last_rst < rec_hs);
      d      = cyc - rec_hs;
      lat    = rec_err ? 1 : (rec_rd ? 3 : 4);
      oh     = ROWS'(1) << rec_addr;
      wr_cmd = live && !rec_err && !rec_rd;
      rd_cmd = live && !rec_err && rec_rd;
      ew     = (wr_cmd && d == 2) ? oh : '0;
      er     = (rd_cmd && (d == 1 || d == 2)) ? oh : '0;
      ec     = (wr_cmd && d >= 1 && d <= 3) ? rec_data : '0;
      busy   = live && d >= 1 && d <= lat;
      check("row_write", 32'(row_write), 32'(ew));
      check("row_read", 32'(row_read), 32'(er));
      check("col_bitWrite", 32'(col_bitWrite), 32'(ec));
      check("cmd_ready", 32'(cmd_ready), 32'(!reset && !busy));
      check("resp_valid", 32'(resp_valid), 32'(live && d == lat));
      inv_w = ~row_write;
      inv_r = ~row_read;
      check("row_writeN_inv", 32'(row_writeN), 32'(inv_w));
      check("row_readN_inv", 32'(row_readN), 32'(inv_r));
      check("strobe_onehot0", 32'($countones(row_write | row_read) <= 1), 32'd1);
      check("wr_rd_overlap", 32'((|row_write) && (|row_read)), 32'd0);
      if (prev_rst) begin
        check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
      end
      if (resp_valid && n_done != n_issued) begin
        e_pop = exp_arr[n_done & 255];
        n_done = n_done + 1;
        check("resp_cycle", 32'(cyc), 32'(e_pop.due));
        check("resp_err", 32'(resp_err), 32'(e_pop.err));
        check("resp_rdata", 32'(resp_rdata), 32'(e_pop.rdata));
        if (e_pop.is_wr && !e_pop.err) ref_mem[e_pop.addr] = e_pop.wdata;
      end else if (n_done != n_issued && cyc > exp_arr[n_done & 255].due) begin
        checks++;
        errors++;
        $display("FAIL resp_timeout: cycle %0d no response, expected by cycle %0d", cyc,
                 exp_arr[n_done & 255].due);
        n_done = n_done + 1;
      end
      if (b2b_seq != b2b_seen) begin
        check("b2b_accept_gap", 32'(b2b_gap), 32'd5);
        b2b_seen = b2b_seq;
      end
      if (reset) begin
        n_done   = n_issued;
        last_rst = cyc;
      end
    end
    prev_rst = reset;
  end

  // Called just after a rising edge; returns just after the edge that accepted the command.
  task automatic issue(input bit op, input int addr, input logic [COLS-1:0] data,
                       input bit keep, output int acc);
    int n;
    n         = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = ADDR_W'(addr);
    cmd_wdata = data;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    if (!cmd_ready) begin
      $display("FAIL accept_timeout: cycle %0d cmd_ready stayed 0, required 1", cyc);
      $fatal(1, "command never accepted");
    end
    acc = cyc;
    @(posedge clk);
    #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  int a1, a2, acc;

  initial begin
    @(posedge clk);
    #1 chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    issue(1'b1, 0, '0, 1'b0, acc);
    repeat (4) @(posedge clk);
    #1;

    issue(1'b0, 2, 16'hA5C3, 1'b0, acc);
    repeat (5) @(posedge clk);
    #1;
    issue(1'b1, 2, '0, 1'b0, acc);
    repeat (4) @(posedge clk);
    #1;

    issue(1'b0, 7, 16'h1234, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1;
    issue(1'b1, 6, '0, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1;

    // Reset lands in the data-setup cycle of this write.
    issue(1'b0, 1, 16'hFFFF, 1'b0, acc);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    issue(1'b1, 1, '0, 1'b0, acc);
    repeat (4) @(posedge clk);
    #1;

    issue(1'b0, 3, 16'h5A0F, 1'b1, a1);
    issue(1'b1, 3, '0, 1'b0, a2);
    b2b_gap = a2 - a1;
    b2b_seq = b2b_seq + 1;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      bit k;
      k = 1'(($urandom_range(0, 1)));
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), COLS'($urandom), k, acc);
      if (!k) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
